// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word, registered
// into a two-entry skid buffer (main/output register plus one skid entry).

package decode_pkg;

  typedef enum logic [5:0] {
    K_INVALID = 6'd0,
    K_LUI, K_AUIPC, K_JAL, K_JALR,
    K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
    K_LB, K_LH, K_LW, K_LBU, K_LHU,
    K_SB, K_SH, K_SW,
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
    K_FENCE, K_FENCE_I, K_ECALL, K_EBREAK,
    K_CSRRW, K_CSRRS, K_CSRRC, K_CSRRWI, K_CSRRSI, K_CSRRCI
  } instr_kind_t;

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [5:0]  out_kind,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [31:0] out_imm,
  output logic [11:0] out_csr,
  output logic        out_illegal
);

  typedef enum logic [2:0] {
    FMT_ZERO, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_UIMM
  } fmt_t;

  typedef struct packed {
    logic [31:0] pc;
    instr_kind_t kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [11:0] csr;
    logic        illegal;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_uimm;

  instr_kind_t dec_kind;
  fmt_t        dec_fmt;
  entry_t      dec_entry;
  entry_t      reset_entry;

  entry_t main_reg, main_next;
  entry_t skid_reg, skid_next;
  logic   main_valid_reg, main_valid_next;
  logic   skid_valid_reg, skid_valid_next;
  logic   accept;
  logic   main_free;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];

  assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u    = {in_instr[31:12], 12'b0};
  assign imm_j    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
  assign imm_uimm = {27'b0, in_instr[19:15]};

  // Classify the incoming word and pick its immediate format.
  always_comb begin
    dec_kind = K_INVALID;
    dec_fmt  = FMT_ZERO;
    unique case (opcode)
      7'b0110111: begin dec_kind = K_LUI;   dec_fmt = FMT_U; end
      7'b0010111: begin dec_kind = K_AUIPC; dec_fmt = FMT_U; end
      7'b1101111: begin dec_kind = K_JAL;   dec_fmt = FMT_J; end
      7'b1100111: begin
        if (funct3 == 3'b000) begin dec_kind = K_JALR; dec_fmt = FMT_I; end
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        case (funct3)
          3'b000:  dec_kind = K_BEQ;
          3'b001:  dec_kind = K_BNE;
          3'b100:  dec_kind = K_BLT;
          3'b101:  dec_kind = K_BGE;
          3'b110:  dec_kind = K_BLTU;
          3'b111:  dec_kind = K_BGEU;
          default: dec_kind = K_INVALID;
        endcase
      end
      7'b0000011: begin
        dec_fmt = FMT_I;
        case (funct3)
          3'b000:  dec_kind = K_LB;
          3'b001:  dec_kind = K_LH;
          3'b010:  dec_kind = K_LW;
          3'b100:  dec_kind = K_LBU;
          3'b101:  dec_kind = K_LHU;
          default: dec_kind = K_INVALID;
        endcase
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        case (funct3)
          3'b000:  dec_kind = K_SB;
          3'b001:  dec_kind = K_SH;
          3'b010:  dec_kind = K_SW;
          default: dec_kind = K_INVALID;
        endcase
      end
      7'b0010011: begin
        dec_fmt = FMT_I;
        case (funct3)
          3'b000:  dec_kind = K_ADDI;
          3'b010:  dec_kind = K_SLTI;
          3'b011:  dec_kind = K_SLTIU;
          3'b100:  dec_kind = K_XORI;
          3'b110:  dec_kind = K_ORI;
          3'b111:  dec_kind = K_ANDI;
          3'b001:  dec_kind = (funct7 == 7'b0000000) ? K_SLLI : K_INVALID;
          3'b101: begin
            if (funct7 == 7'b0000000)      dec_kind = K_SRLI;
            else if (funct7 == 7'b0100000) dec_kind = K_SRAI;
            else                           dec_kind = K_INVALID;
          end
          default: dec_kind = K_INVALID;
        endcase
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_kind = K_ADD;
            3'b001:  dec_kind = K_SLL;
            3'b010:  dec_kind = K_SLT;
            3'b011:  dec_kind = K_SLTU;
            3'b100:  dec_kind = K_XOR;
            3'b101:  dec_kind = K_SRL;
            3'b110:  dec_kind = K_OR;
            default: dec_kind = K_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      dec_kind = K_SUB;
          else if (funct3 == 3'b101) dec_kind = K_SRA;
        end
      end
      7'b0001111: begin
        if (funct3 == 3'b000)      dec_kind = K_FENCE;
        else if (funct3 == 3'b001) dec_kind = K_FENCE_I;
      end
      7'b1110011: begin
        case (funct3)
          3'b000: begin
            if (in_instr[31:7] == 25'd0)
              dec_kind = K_ECALL;
            else if (in_instr[31:20] == 12'd1 && in_instr[19:7] == 13'd0)
              dec_kind = K_EBREAK;
          end
          3'b001:  begin dec_kind = K_CSRRW;  dec_fmt = FMT_I;    end
          3'b010:  begin dec_kind = K_CSRRS;  dec_fmt = FMT_I;    end
          3'b011:  begin dec_kind = K_CSRRC;  dec_fmt = FMT_I;    end
          3'b101:  begin dec_kind = K_CSRRWI; dec_fmt = FMT_UIMM; end
          3'b110:  begin dec_kind = K_CSRRSI; dec_fmt = FMT_UIMM; end
          3'b111:  begin dec_kind = K_CSRRCI; dec_fmt = FMT_UIMM; end
          default: dec_kind = K_INVALID;
        endcase
      end
      default: dec_kind = K_INVALID;
    endcase
    // An unrecognised word never carries an immediate.
    if (dec_kind == K_INVALID) dec_fmt = FMT_ZERO;
  end

  // Assemble the decoded entry that gets captured on acceptance.
  always_comb begin
    dec_entry         = '0;
    dec_entry.pc      = in_pc;
    dec_entry.kind    = dec_kind;
    dec_entry.rd      = in_instr[11:7];
    dec_entry.rs1     = in_instr[19:15];
    dec_entry.rs2     = in_instr[24:20];
    dec_entry.csr     = in_instr[31:20];
    dec_entry.illegal = (dec_kind == K_INVALID);
    case (dec_fmt)
      FMT_I:    dec_entry.imm = imm_i;
      FMT_S:    dec_entry.imm = imm_s;
      FMT_B:    dec_entry.imm = imm_b;
      FMT_U:    dec_entry.imm = imm_u;
      FMT_J:    dec_entry.imm = imm_j;
      FMT_UIMM: dec_entry.imm = imm_uimm;
      default:  dec_entry.imm = 32'd0;
    endcase
  end

  // Output register contents presented after reset.
  always_comb begin
    reset_entry      = '0;
    reset_entry.pc   = RESET_PC;
    reset_entry.kind = K_INVALID;
  end

  // in_ready depends only on registered skid occupancy (and reset), never on out_ready.
  assign in_ready  = ~skid_valid_reg & ~rst;
  assign accept    = in_valid & in_ready & ~flush;
  assign main_free = ~main_valid_reg | out_ready;

  // Skid-buffer next state: refill main from skid first, else from the decoder.
  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (main_free) begin
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        main_valid_next = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_next       = dec_entry;
        main_valid_next = 1'b1;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_next       = dec_entry;
      skid_valid_next = 1'b1;
    end
  end

  // Buffer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg       <= reset_entry;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  assign out_valid   = main_valid_reg;
  assign out_pc      = main_reg.pc;
  assign out_kind    = main_reg.kind;
  assign out_rd      = main_reg.rd;
  assign out_rs1     = main_reg.rs1;
  assign out_rs2     = main_reg.rs2;
  assign out_imm     = main_reg.imm;
  assign out_csr     = main_reg.csr;
  assign out_illegal = main_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: a mask/match opcode table decodes each
// accepted word, and a queue stands in for the two-entry buffer.

module tb_decode_stage;
  import decode_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  localparam int F_ZERO = 0;
  localparam int F_I    = 1;
  localparam int F_S    = 2;
  localparam int F_B    = 3;
  localparam int F_U    = 4;
  localparam int F_J    = 5;
  localparam int F_UIMM = 6;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_pc, in_instr, out_pc, out_imm;
  logic [5:0]  out_kind;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [11:0] out_csr;

  always #5 clk = ~clk;

  decode_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_kind(out_kind), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_csr(out_csr), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          dir;
    int          kind;
    int          rd;
    int          rs1;
    logic [31:0] imm;
    bit          imm_en;
    int          csr;
  } src_t;

  typedef struct {
    logic [31:0] pc;
    int          kind;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [11:0] csr;
    src_t        s;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_cons   = 0;
  bit fresh    = 1'b0;
  logic [31:0] pc_ctr = 32'h0000_2000;

  src_t src[$];
  exp_t q[$];

  logic [31:0] t_mask[$];
  logic [31:0] t_match[$];
  int          t_kind[$];
  int          t_fmt[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void add(input logic [31:0] m, input logic [31:0] v, input int k, input int f);
    t_mask.push_back(m);
    t_match.push_back(v);
    t_kind.push_back(k);
    t_fmt.push_back(f);
  endfunction

  // Instruction table in mask/match form; funct3 goes to bits [14:12].
  function automatic void build_table();
    int br[6] = '{K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU};
    int brf[6] = '{0, 1, 4, 5, 6, 7};
    int ld[5] = '{K_LB, K_LH, K_LW, K_LBU, K_LHU};
    int ldf[5] = '{0, 1, 2, 4, 5};
    int st[3] = '{K_SB, K_SH, K_SW};
    int ai[6] = '{K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI};
    int aif[6] = '{0, 2, 3, 4, 6, 7};
    int rr[8] = '{K_ADD, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_OR, K_AND};
    int cs[6] = '{K_CSRRW, K_CSRRS, K_CSRRC, K_CSRRWI, K_CSRRSI, K_CSRRCI};
    int csf[6] = '{1, 2, 3, 5, 6, 7};
    add(32'h7F, 32'h37, K_LUI, F_U);
    add(32'h7F, 32'h17, K_AUIPC, F_U);
    add(32'h7F, 32'h6F, K_JAL, F_J);
    add(32'h707F, 32'h67, K_JALR, F_I);
    for (int n = 0; n < 6; n++) add(32'h707F, 32'h63 | (brf[n] << 12), br[n], F_B);
    for (int n = 0; n < 5; n++) add(32'h707F, 32'h03 | (ldf[n] << 12), ld[n], F_I);
    for (int n = 0; n < 3; n++) add(32'h707F, 32'h23 | (n << 12), st[n], F_S);
    for (int n = 0; n < 6; n++) add(32'h707F, 32'h13 | (aif[n] << 12), ai[n], F_I);
    add(32'hFE00707F, 32'h00001013, K_SLLI, F_I);
    add(32'hFE00707F, 32'h00005013, K_SRLI, F_I);
    add(32'hFE00707F, 32'h40005013, K_SRAI, F_I);
    for (int n = 0; n < 8; n++) add(32'hFE00707F, 32'h33 | (n << 12), rr[n], F_ZERO);
    add(32'hFE00707F, 32'h40000033, K_SUB, F_ZERO);
    add(32'hFE00707F, 32'h40005033, K_SRA, F_ZERO);
    add(32'h707F, 32'h0F, K_FENCE, F_ZERO);
    add(32'h707F, 32'h100F, K_FENCE_I, F_ZERO);
    add(32'hFFFFFFFF, 32'h00000073, K_ECALL, F_ZERO);
    add(32'hFFFFFFFF, 32'h00100073, K_EBREAK, F_ZERO);
    for (int n = 0; n < 6; n++)
      add(32'h707F, 32'h73 | (csf[n] << 12), cs[n], (csf[n] > 4) ? F_UIMM : F_I);
  endfunction

  function automatic exp_t model(input src_t s);
    exp_t        e;
    logic [31:0] i = s.instr;
    logic [31:0] sx = i[31] ? 32'hFFFF_FFFF : 32'h0;
    int          k = K_INVALID;
    int          f = F_ZERO;
    bit          found = 1'b0;
    for (int n = 0; n < t_mask.size(); n++) begin
      if (!found && (i & t_mask[n]) == t_match[n]) begin
        found = 1'b1;
        k = t_kind[n];
        f = t_fmt[n];
      end
    end
    case (f)
      F_I:    e.imm = (sx & 32'hFFFF_F000) | (i >> 20);
      F_S:    e.imm = (sx & 32'hFFFF_F000) | ((i >> 20) & 32'hFE0) | ((i >> 7) & 32'h1F);
      F_B:    e.imm = (sx & 32'hFFFF_F000) | (((i >> 7) & 32'h1) << 11)
                      | (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
      F_U:    e.imm = i & 32'hFFFF_F000;
      F_J:    e.imm = (sx & 32'hFFF0_0000) | (i & 32'h000F_F000)
                      | (((i >> 20) & 32'h1) << 11) | (((i >> 21) & 32'h3FF) << 1);
      F_UIMM: e.imm = (i >> 15) & 32'h1F;
      default: e.imm = 32'h0;
    endcase
    e.pc   = s.pc;
    e.kind = k;
    e.rd   = 5'((i >> 7) & 32'h1F);
    e.rs1  = 5'((i >> 15) & 32'h1F);
    e.rs2  = 5'((i >> 20) & 32'h1F);
    e.csr  = 12'(i >> 20);
    e.s    = s;
    return e;
  endfunction

  function automatic void push_dir(input logic [31:0] instr, input int kind, input int rd,
                                   input int rs1, input logic [31:0] imm, input bit imm_en,
                                   input int csr);
    src_t s;
    s.instr = instr; s.pc = pc_ctr; s.dir = 1'b1; s.kind = kind; s.rd = rd; s.rs1 = rs1;
    s.imm = imm; s.imm_en = imm_en; s.csr = csr;
    pc_ctr += 4;
    src.push_back(s);
  endfunction

  function automatic void push_rand();
    src_t s;
    int   n;
    if ($urandom_range(0, 9) < 6) begin
      n = $urandom_range(0, t_mask.size() - 1);
      s.instr = t_match[n] | ($urandom & ~t_mask[n]);
    end else begin
      s.instr = $urandom;
    end
    s.pc = $urandom & 32'hFFFF_FFFC;
    s.dir = 1'b0; s.kind = 0; s.rd = 0; s.rs1 = 0; s.imm = 0; s.imm_en = 1'b0; s.csr = -1;
    src.push_back(s);
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input bit ordy, input bit ven, input bit fl, input bit r);
    bit pres, exp_rdy, acc, cons;
    pres      = ven && (src.size() > 0);
    in_valid  = pres;
    in_instr  = pres ? src[0].instr : $urandom;
    in_pc     = pres ? src[0].pc : $urandom;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    exp_rdy = !r && (q.size() < 2);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("pc", out_pc, q[0].pc);
      check("kind", 32'(out_kind), 32'(q[0].kind));
      check("illegal", 32'(out_illegal), 32'(q[0].kind == K_INVALID));
      check("rd", 32'(out_rd), 32'(q[0].rd));
      check("rs1", 32'(out_rs1), 32'(q[0].rs1));
      check("rs2", 32'(out_rs2), 32'(q[0].rs2));
      check("imm", out_imm, q[0].imm);
      check("csr", 32'(out_csr), 32'(q[0].csr));
      if (q[0].s.dir) begin
        check("dir_kind", 32'(out_kind), 32'(q[0].s.kind));
        check("dir_rd", 32'(out_rd), 32'(q[0].s.rd));
        check("dir_rs1", 32'(out_rs1), 32'(q[0].s.rs1));
        if (q[0].s.imm_en) check("dir_imm", out_imm, q[0].s.imm);
        if (q[0].s.csr >= 0) check("dir_csr", 32'(out_csr), 32'(q[0].s.csr));
      end
    end else if (fresh) begin
      check("rst_pc", out_pc, RST_PC);
      check("rst_kind", 32'(out_kind), 32'(K_INVALID));
      check("rst_illegal", 32'(out_illegal), 32'd0);
      check("rst_fields", {12'd0, out_rd, out_rs1, out_rs2}, 32'd0);
      check("rst_imm", out_imm, 32'd0);
      check("rst_csr", 32'(out_csr), 32'd0);
    end
    acc  = pres && exp_rdy && !fl && !r;
    cons = (q.size() > 0) && ordy;
    if (r || fl) begin
      q.delete();
      if (r) fresh = 1'b1;
      if (fl && pres) void'(src.pop_front());
    end else begin
      if (cons) begin
        $display("tx %0d pc=%h kind=%0d rd=%0d rs1=%0d rs2=%0d imm=%h", n_cons, out_pc,
                 out_kind, out_rd, out_rs1, out_rs2, out_imm);
        n_cons++;
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(model(src[0]));
        void'(src.pop_front());
        n_acc++;
        fresh = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, c0;
    build_table();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_instr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    fresh = 1'b1;
    step(1, 0, 0, 1);

    // Streaming at full rate.
    push_dir(32'h00500093, K_ADDI, 1, 0, 32'd5, 1, -1);
    push_dir(32'h123452B7, K_LUI, 5, 8, 32'h12345000, 1, -1);
    push_dir(32'hFE000EE3, K_BEQ, 29, 0, 32'hFFFFFFFC, 1, -1);
    repeat (5) step(1, 1, 0, 0);

    // Format sweep and illegal words.
    push_dir(32'h402081B3, K_SUB, 3, 1, 32'd0, 1, -1);
    push_dir(32'h00000073, K_ECALL, 0, 0, 32'd0, 1, -1);
    push_dir(32'h00100073, K_EBREAK, 0, 0, 32'd0, 1, -1);
    push_dir(32'h30529073, K_CSRRW, 0, 5, 32'd0, 0, 12'h305);
    push_dir(32'h00000000, K_INVALID, 0, 0, 32'd0, 1, -1);
    push_dir(32'h0000707F, K_INVALID, 0, 0, 32'd0, 1, -1);
    push_dir(32'h4000A0B3, K_INVALID, 1, 1, 32'd0, 1, -1);
    repeat (10) step(1, 1, 0, 0);

    // Backpressure: three offered, two taken.
    repeat (3) push_rand();
    a0 = n_acc;
    repeat (4) step(0, 1, 0, 0);
    check("bp_accepted", 32'(n_acc - a0), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    c0 = n_cons;
    repeat (6) step(1, 1, 0, 0);
    check("bp_delivered", 32'(n_cons - c0), 32'd3);

    // Flush with both entries full and a third word presented.
    repeat (3) push_rand();
    a0 = n_acc;
    repeat (3) step(0, 1, 0, 0);
    check("fl_filled", 32'(n_acc - a0), 32'd2);
    step(1, 1, 1, 0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    repeat (3) step(1, 1, 0, 0);

    // Reset in the middle of a stream.
    repeat (4) push_rand();
    repeat (3) step(1'($urandom_range(0, 1)), 1, 0, 0);
    step(1, 1, 0, 1);
    src.delete();
    push_dir(32'h00500093, K_ADDI, 1, 0, 32'd5, 1, -1);
    repeat (3) step(1, 1, 0, 0);

    // Random traffic with occasional flush and reset.
    repeat (3000) begin
      if (src.size() < 3) push_rand();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (4) step(1, 0, 0, 0);
    check("drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
